// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register pending-write scoreboard driving issue stall, operand forwarding and a stall counter
module pipe_scoreboard #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int WB_LAT = 3,
  parameter bit FWD_EN = 1'b1,
  parameter bit RF_BYP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs,
  input  logic            issue_rs_en,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_rt_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_rd_en,
  input  logic            issue_load,
  input  logic            flush,
  output logic            stall,
  output logic [1:0]      fwd_rs_sel,
  output logic [1:0]      fwd_rt_sel,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_cnt
);
  localparam int CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT  = CW'(WB_LAT);
  localparam logic [CW-1:0] LAT1 = CW'(WB_LAT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  logic [CW-1:0] cnt [NREG];
  logic [NREG-1:0] ld;
  logic [2:0] rs_chk, rt_chk;
  logic accept;
  // {hazard, sel} for one source; resolved check first so WB_LAT=2 with RF_BYP never forwards from WB
  function automatic logic [2:0] src_chk(input logic en, input logic [AW-1:0] s,
                                          input logic [CW-1:0] c, input logic l);
    if (!en || s == '0 || c == '0 || (RF_BYP && c == ONE)) return 3'b0_00;
    if (FWD_EN && c == LAT && !l) return 3'b0_01;
    if (c == LAT) return 3'b1_00;
    if (FWD_EN && c == LAT1) return 3'b0_10;
    return 3'b1_00;
  endfunction
  always_comb begin
    rs_chk = src_chk(issue_rs_en, issue_rs, cnt[issue_rs], ld[issue_rs]);
    rt_chk = src_chk(issue_rt_en, issue_rt, cnt[issue_rt], ld[issue_rt]);
    stall = issue_valid & ~flush & (rs_chk[2] | rt_chk[2]);
    accept = issue_valid & ~stall & ~flush;
    fwd_rs_sel = accept ? rs_chk[1:0] : 2'd0;
    fwd_rt_sel = accept ? rt_chk[1:0] : 2'd0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = cnt[r] != '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      ld <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (accept && issue_rd_en && issue_rd == AW'(r)) begin
          cnt[r] <= LAT;
          ld[r] <= issue_load;
        end else if (flush && cnt[r] == LAT) cnt[r] <= '0;
        else if (cnt[r] != '0) cnt[r] <= cnt[r] - ONE;
      end
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
